// File: rtl/rib_arbiter_if.sv
// ----------------------------------------------------------------------------
// rib_arbiter_if -- request/grant bundle between the RIB bus masters and the
// round-robin arbiter.
//
// Signals:
//   req_i       [NUM_MASTERS-1:0]  per-master request, held for the transaction
//   gnt_o       [NUM_MASTERS-1:0]  registered one-hot grant (zero when no owner)
//   gnt_id_o    [1:0]              index of the current owner (0 when no owner)
//   gnt_vld_o                      high while any master owns the bus
//   hold_flag_o                    core stall request
//   timeout_o                      one-cycle pulse on a forced release
//
// Modports:
//   master -- the requesting side (drives req_i)
//   slave  -- the arbiter (drives grant/status)
// ----------------------------------------------------------------------------
interface rib_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  logic [NUM_MASTERS-1:0] req_i;
  logic [NUM_MASTERS-1:0] gnt_o;
  logic [1:0]             gnt_id_o;
  logic                   gnt_vld_o;
  logic                   hold_flag_o;
  logic                   timeout_o;

  modport master (
    output req_i,
    input  gnt_o, gnt_id_o, gnt_vld_o, hold_flag_o, timeout_o
  );

  modport slave (
    input  req_i,
    output gnt_o, gnt_id_o, gnt_vld_o, hold_flag_o, timeout_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// ----------------------------------------------------------------------------
// rib_arbiter -- round-robin owner arbiter for the RIB bus.
//
// Masters: 0 = core EX, 1 = core PC, 2 = JTAG, 3 = UART debug.
// A master that wins keeps the bus for as long as its request stays high;
// when it drops, the pointer moves just past it and the grant passes to the
// next requester on the same edge (no idle cycle), or the arbiter goes idle.
//
// Ports:
//   clk  -- single clock, rising edge
//   rst  -- asynchronous, active-low reset
//   bus  -- rib_arbiter_if.slave (req_i in; gnt_o, gnt_id_o, gnt_vld_o,
//           hold_flag_o, timeout_o out)
//
// Parameters:
//   NUM_MASTERS    -- number of arbitrated masters (default 4)
//   TIMEOUT_CYCLES -- owned-cycle limit before a forced release (default 255)
//
// Build option:
//   RIB_ARB_TIMEOUT_EN -- when defined, an owned-cycle counter forces the
//   owner off the bus after TIMEOUT_CYCLES cycles if someone else is waiting,
//   and timeout_o pulses for that release. When undefined, timeout_o is tied
//   low and ownership ends only when the owner drops its request.
// ----------------------------------------------------------------------------
module rib_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  rib_arbiter_if.slave bus
);

  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic                   r_gnt_vld;

  logic [NUM_MASTERS-1:0] w_other;
  logic                   w_owner_req;
  logic                   w_force;
  logic                   w_release;
  logic [IDX_W-1:0]       w_next_ptr;
  logic [IDX_W-1:0]       w_idle_pick;
  logic [IDX_W-1:0]       w_busy_pick;

  // First set bit of mask at or after ptr, searching upward with wrap.
  function automatic logic [IDX_W-1:0] f_rr_pick(
    input logic [NUM_MASTERS-1:0] mask,
    input logic [IDX_W-1:0]       ptr
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!found && mask[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] owner);
    if (int'(owner) == NUM_MASTERS - 1) return '0;
    else                                return owner + 1'b1;
  endfunction

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_W'(TIMEOUT_CYCLES)) return cnt;
    else                               return cnt + 1'b1;
  endfunction

  // Force only when someone else is waiting; a lone owner keeps the bus.
  assign w_force = (r_state == ST_BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) && (|w_other);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
  assign w_force      = 1'b0;
`endif

  always_comb begin
    w_owner_req = bus.req_i[r_owner];
    // Exclude the current owner so a drop-and-reraise cannot win again
    // ahead of others; the advanced pointer already puts it last.
    w_other     = bus.req_i & ~r_gnt;
    w_release   = (r_state == ST_BUSY) && (!w_owner_req || w_force);
    w_next_ptr  = f_next_ptr(r_owner);
    w_idle_pick = f_rr_pick(bus.req_i, r_rr_ptr);
    w_busy_pick = f_rr_pick(w_other, w_next_ptr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_gnt_vld <= 1'b0;
`ifdef RIB_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef RIB_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|bus.req_i) begin
            r_state   <= ST_BUSY;
            r_gnt     <= f_onehot(w_idle_pick);
            r_owner   <= w_idle_pick;
            r_gnt_vld <= 1'b1;
`ifdef RIB_ARB_TIMEOUT_EN
            r_cnt     <= CNT_W'(1);
`endif
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_rr_ptr <= w_next_ptr;
            if (|w_other) begin
              // Direct hand-over, no idle cycle in between.
              r_gnt     <= f_onehot(w_busy_pick);
              r_owner   <= w_busy_pick;
`ifdef RIB_ARB_TIMEOUT_EN
              r_cnt     <= CNT_W'(1);
              r_timeout <= w_force && w_owner_req;
`endif
            end else begin
              r_state   <= ST_IDLE;
              r_gnt     <= '0;
              r_owner   <= '0;
              r_gnt_vld <= 1'b0;
`ifdef RIB_ARB_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end else begin
`ifdef RIB_ARB_TIMEOUT_EN
            r_cnt <= f_sat_inc(r_cnt);
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.gnt_id_o  = r_owner;
  assign bus.gnt_vld_o = r_gnt_vld;

  // Core stalls while a debug master owns the bus, or while EX is asking
  // and has not been granted yet.
  assign bus.hold_flag_o = (r_gnt_vld && (r_owner >= 2'd2)) ||
                           (bus.req_i[0] && !r_gnt[0]);

`ifdef RIB_ARB_TIMEOUT_EN
  assign bus.timeout_o = r_timeout;
`else
  assign bus.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rib_arbiter.sv
module tb_rib_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rib_arbiter_if #(.NUM_MASTERS(4)) bus ();

  rib_arbiter #(
    .NUM_MASTERS   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
    logic       hold;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r);
    bus.req_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                         input logic vld, input logic hold);
    chk({tag, ".gnt"},  32'(bus.gnt_o),       32'(gnt));
    chk({tag, ".id"},   32'(bus.gnt_id_o),    32'(id));
    chk({tag, ".vld"},  32'(bus.gnt_vld_o),   32'(vld));
    chk({tag, ".hold"}, 32'(bus.hold_flag_o), 32'(hold));
  endtask

  // Global time limit so the run always ends by itself.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    logic [1:0] own;
    logic       hold;

    // req, expected gnt, id, vld, hold (after the edge, req still applied)
    vecs[0]  = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[2]  = '{4'b1101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[3]  = '{4'b1101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[4]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[5]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[8]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[9]  = '{4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[12] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[13] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[15] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    rst       = 1'b0;
    bus.req_i = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.tmo", 32'(bus.timeout_o), 32'd0);
    #2 rst = 1'b1;

    // Directed table: grant, hold, hand-over, idle, pointer rotation.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].req);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].vld, vecs[i].hold);
    end

    // Reset mid-grant: grant drops immediately, restart from pointer 0.
    step(4'b0100);
    chk_all("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req_i = 4'b1000;
    @(posedge clk);
    #1;
    chk("rst_held.gnt", 32'(bus.gnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'b1000, 2'd3, 1'b1, 1'b1);
    step(4'b0000);
    chk_all("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All four requesting; each drops after 3 owned cycles -> 0,1,2,3,0.
    for (int k = 0; k < 15; k++) begin
      r = 4'b1111;
      if (k > 0 && (k % 3) == 0) r[((k - 1) / 3) % 4] = 1'b0;
      own  = 2'((k / 3) % 4);
      hold = (own >= 2'd2) || (r[0] && own != 2'd0);
      step(r);
      chk_all($sformatf("rr%0d", k), 4'b0001 << own, own, 1'b1, hold);
    end

    // Timeout behaviour: master 3 owns while master 0 waits.
    step(4'b0000);
    chk("to_idle.vld", 32'(bus.gnt_vld_o), 32'd0);
    step(4'b1000);
    chk("to_grant.gnt", 32'(bus.gnt_o), 32'h8);
    for (int i = 1; i <= 9; i++) begin
      step(4'b1001);
`ifdef RIB_ARB_TIMEOUT_EN
      chk($sformatf("to%0d.gnt", i), 32'(bus.gnt_o), (i >= 8) ? 32'h1 : 32'h8);
      chk($sformatf("to%0d.tmo", i), 32'(bus.timeout_o), (i == 8) ? 32'd1 : 32'd0);
`else
      chk($sformatf("to%0d.gnt", i), 32'(bus.gnt_o), 32'h8);
      chk($sformatf("to%0d.tmo", i), 32'(bus.timeout_o), 32'd0);
`endif
    end

    // Lone owner keeps the bus indefinitely.
    step(4'b0000);
    chk("alone_idle.vld", 32'(bus.gnt_vld_o), 32'd0);
    step(4'b1000);
    chk("alone_grant.gnt", 32'(bus.gnt_o), 32'h8);
    for (int i = 0; i < 20; i++) begin
      step(4'b1000);
      chk($sformatf("alone%0d.gnt", i), 32'(bus.gnt_o), 32'h8);
      chk($sformatf("alone%0d.tmo", i), 32'(bus.timeout_o), 32'd0);
    end

    // Random requests: one-hot-or-zero, never a non-requesting master.
    for (int c = 0; c < 10000; c++) begin
      r = 4'($urandom_range(0, 15));
      step(r);
      chk("rand_onehot0", 32'($onehot0(bus.gnt_o)), 32'd1);
      chk("rand_nonreq", 32'(bus.gnt_o & ~r), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
RIB_ARBITER -- requirements
Module: rib_arbiter

Interface
REQ-001 SHALL take parameter NUM_MASTERS, default 4: number of bus masters arbitrated (index 0 = core EX, 1 = core PC, 2 = JTAG, 3 = UART debug).
REQ-002 SHALL take parameter TIMEOUT_CYCLES, default 255: maximum consecutive owned cycles before a forced release (used only when the timeout feature is compiled in).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  NUM_MASTERS  per-master request; high for the whole transaction.
REQ-006 SHALL have port gnt_o  output  NUM_MASTERS  registered one-hot grant; all zero when no owner.
REQ-007 SHALL have port gnt_id_o  output  2  index of the current owner; 0 when there is no owner.
REQ-008 SHALL have port gnt_vld_o  output  1  high while any master owns the bus.
REQ-009 SHALL have port hold_flag_o  output  1  core stall; high while master 2 or 3 owns, or while req_i[0] is high and master 0 is not granted.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement two states: IDLE (no owner) and BUSY (one owner).
REQ-012 In IDLE, with any req_i bit high at an edge, SHALL enter BUSY and grant the round-robin winner at that edge (latency 1 cycle from request to gnt_o).
REQ-013 Round-robin winner SHALL be the first requesting index at or after rr_ptr, searching upward modulo NUM_MASTERS.
REQ-014 In BUSY, the grant SHALL stay fixed while req_i[owner] stays high; requests from other masters SHALL NOT change gnt_o.
REQ-015 When req_i[owner] is low at an edge, rr_ptr SHALL become (owner+1) mod NUM_MASTERS.
REQ-016 On that same edge, if any other request is high, the grant SHALL pass directly to the new winner with no idle cycle; otherwise the block SHALL go to IDLE.
REQ-017 A master whose request drops and rises again in the same release edge SHALL NOT be re-granted ahead of other requesters; it is last in the new rotation.
REQ-018 gnt_o SHALL never have more than one bit set.
REQ-019 gnt_o SHALL never be set for a master whose req_i was low at the granting edge.
REQ-020 hold_flag_o SHALL be combinational from registered grant state and req_i.
REQ-021 rr_ptr SHALL wrap from NUM_MASTERS-1 to 0.

Reset
REQ-022 With rst low, SHALL immediately (asynchronously) force state to IDLE and clear gnt_o, gnt_id_o, gnt_vld_o, timeout_o and the owned-cycle counter; rr_ptr SHALL reset to 0.
REQ-023 Reset asserted mid-transaction SHALL drop the grant with no completion; after release, arbitration SHALL restart from rr_ptr=0 at the first edge.

Configuration
REQ-024 Macro RIB_ARB_TIMEOUT_EN, when defined, SHALL include an owned-cycle counter.
REQ-025 With RIB_ARB_TIMEOUT_EN defined, the counter SHALL reset to 1 on each new grant and increment per BUSY cycle, saturating at TIMEOUT_CYCLES.
REQ-026 With RIB_ARB_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES and any other master requests, the next edge SHALL force a release exactly as in REQ-015/016 and pulse timeout_o for one cycle.
REQ-027 With RIB_ARB_TIMEOUT_EN defined, when no other master requests, the owner SHALL keep the grant indefinitely.
REQ-028 Without RIB_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be tied 0, and ownership SHALL end only by req_i drop.

Verification
REQ-029 SHALL cover: reset released, req_i=4'b0110 at edge 1 -> gnt_o=4'b0010, gnt_id_o=1 after edge 1; hold_flag_o=0.
REQ-030 SHALL cover: owner 1 drops req while req_i=4'b1101 -> next edge gnt_o=4'b0100 (index 2), hold_flag_o=1, no idle cycle.
REQ-031 SHALL cover: all four requesting continuously, each dropping after 3 owned cycles -> grant order 0,1,2,3,0 and each master owns exactly 3 cycles.
REQ-032 SHALL cover: with RIB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, master 3 holds req while master 0 requests -> after 8 owned cycles gnt_o=4'b0001 and timeout_o high for exactly 1 cycle; if master 0 is idle instead, master 3 keeps the grant and timeout_o stays 0.
REQ-033 SHALL cover: rst driven low mid-grant between edges -> gnt_o=0 immediately; after release with req_i=4'b1000 -> gnt_o=4'b1000 one edge later.
REQ-034 SHALL cover: random req_i for 10k cycles -> assertions that gnt_o is one-hot-or-zero and never grants a non-requesting master.
